// File: rtl/decade_count_ctrl_pkg.sv
// Shared constants for the decade counter controller: state encodings and BCD limits.
package decade_count_ctrl_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Out-of-range preset nibbles load as 9 so a digit never holds a non-BCD code.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/decade_count_ctrl_digit.sv
// One synchronous mod-10 digit with clamped parallel load; tc flags the digit at 9.
module decade_digit
    import decade_count_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] q,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!clear) begin
            q <= '0;
        end else if (load) begin
            q <= bcd_clamp(load_val);
        end else if (en) begin
            q <= (q == BCD_MAX) ? '0 : q + 1'b1;
        end
    end

    assign tc = (q == BCD_MAX);

endmodule

// File: rtl/decade_count_ctrl.sv
// Run/pause/preset controller for a cascade of decade digits forming a BCD event counter.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start or preset
//   ST_RUN   | ticks are counted
//   ST_PAUSE | count frozen, preset or start accepted
//   ST_HOLD  | terminal count reached with WRAP=0, only preset leaves
module decade_count_ctrl
    import decade_count_ctrl_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    tick,
    input  logic                    lap,
    input  logic                    preset_en,
    input  logic [BCD_W*DIGITS-1:0] preset_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic [BCD_W*DIGITS-1:0] lap_val,
    output logic                    running,
    output logic                    done,
    output logic                    overflow
);

    localparam logic WRAP_EN = (WRAP != 0);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DIGITS-1:0] tc;
    logic [DIGITS-1:0] carry;
    logic              run_tick;
    logic              at_max;
    logic              cnt_en;
    logic              load;

    assign run_tick = (state == ST_RUN) && tick;
    assign at_max   = run_tick && (&tc);
    // Without wrap the all-9s tick is swallowed so the count parks at its maximum.
    assign cnt_en   = run_tick && !(at_max && !WRAP_EN);
    assign load     = preset_en && (state != ST_RUN);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            if (g == 0) begin : g_first
                assign carry[g] = cnt_en;
            end else begin : g_next
                assign carry[g] = carry[g-1] && tc[g-1];
            end

            decade_digit u_digit (
                .clk      (clk),
                .clear    (clear),
                .en       (carry[g]),
                .load     (load),
                .load_val (preset_val[g*BCD_W +: BCD_W]),
                .q        (count[g*BCD_W +: BCD_W]),
                .tc       (tc[g])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_PAUSE: begin
                if (preset_en) begin
                    state_nxt = ST_PAUSE;
                end else if (start && !stop) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_PAUSE;
                end else if (at_max && !WRAP_EN) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (preset_en) begin
                    state_nxt = ST_PAUSE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state    <= ST_IDLE;
            lap_val  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= at_max && WRAP_EN;
            if (lap) begin
                lap_val <= count;
            end
        end
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_HOLD);

endmodule
